// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions: widths, data-position table and helpers
// used by the syndrome stage and the downstream XOR correction stage.
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CW_W   = 15;
  localparam int SYN_W  = 4;

  // Codeword position (1-based) that carries each data bit, data[0] first
  localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  function automatic logic [SYN_W-1:0] calcSyndrome(input logic [CW_W-1:0] cw);
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int p = 1; p <= CW_W; p++) begin
      if (cw[p-1]) syn = syn ^ p[SYN_W-1:0];
    end
    return syn;
  endfunction

  function automatic logic [DATA_W-1:0] extractData(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] data;
    data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = cw[DATA_POS[i] - 4'd1];
    end
    return data;
  endfunction

endpackage

// File: rtl/syndrome_to_mask.sv
// Combinational decode of a Hamming syndrome into a one-hot data error mask
// and a flag for syndromes that point at a parity position.
module syndrome_to_mask
  import hamming_pkg::*;
(
  input  logic [SYN_W-1:0]  syn_i,
  output logic [DATA_W-1:0] mask_o,
  output logic              perr_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask_o[i] = (syn_i == DATA_POS[i]);
    end
  end

  assign perr_o = (syn_i == 4'd1) || (syn_i == 4'd2) ||
                  (syn_i == 4'd4) || (syn_i == 4'd8);

endmodule

// File: rtl/syndrome_stage.sv
// Two-stage valid/ready pipeline computing the Hamming(15,11) syndrome and
// error mask, plus a saturating count of delivered erroneous words.
module syndrome_stage
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_mask,
  output logic [SYN_W-1:0]  out_syn,
  output logic              out_perr,
  output logic [CNT_W-1:0]  err_count
);

  logic              s1Valid_q, s1Valid_d;
  logic [CW_W-1:0]   s1Cw_q, s1Cw_d;
  logic [SYN_W-1:0]  s1Syn_q, s1Syn_d;
  logic              s2Valid_q, s2Valid_d;
  logic [DATA_W-1:0] s2Data_q, s2Data_d;
  logic [DATA_W-1:0] s2Mask_q, s2Mask_d;
  logic [SYN_W-1:0]  s2Syn_q, s2Syn_d;
  logic              s2Perr_q, s2Perr_d;
  logic [CNT_W-1:0]  errCount_q, errCount_d;

  logic              s1Adv, s2Adv;
  logic [DATA_W-1:0] decMask;
  logic              decPerr;

  syndrome_to_mask uDecode (
    .syn_i  (s1Syn_q),
    .mask_o (decMask),
    .perr_o (decPerr)
  );

  // Ready ripples back combinationally so a full pipe streams without bubbles
  assign s2Adv    = !s2Valid_q || out_ready;
  assign s1Adv    = !s1Valid_q || s2Adv;
  assign in_ready = s1Adv;

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Cw_d     = s1Cw_q;
    s1Syn_d    = s1Syn_q;
    s2Valid_d  = s2Valid_q;
    s2Data_d   = s2Data_q;
    s2Mask_d   = s2Mask_q;
    s2Syn_d    = s2Syn_q;
    s2Perr_d   = s2Perr_q;
    errCount_d = errCount_q;

    if (s1Adv) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Cw_d  = in_cw;
        s1Syn_d = calcSyndrome(in_cw);
      end
    end

    if (s2Adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Data_d = extractData(s1Cw_q);
        s2Mask_d = decMask;
        s2Syn_d  = s1Syn_q;
        s2Perr_d = decPerr;
      end
    end

    // Count only words actually handed downstream, and stop at all-ones
    if (s2Valid_q && out_ready && (s2Syn_q != '0) && (errCount_q != '1)) begin
      errCount_d = errCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q  <= 1'b0;
      s1Cw_q     <= '0;
      s1Syn_q    <= '0;
      s2Valid_q  <= 1'b0;
      s2Data_q   <= '0;
      s2Mask_q   <= '0;
      s2Syn_q    <= '0;
      s2Perr_q   <= 1'b0;
      errCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Cw_q     <= s1Cw_d;
      s1Syn_q    <= s1Syn_d;
      s2Valid_q  <= s2Valid_d;
      s2Data_q   <= s2Data_d;
      s2Mask_q   <= s2Mask_d;
      s2Syn_q    <= s2Syn_d;
      s2Perr_q   <= s2Perr_d;
      errCount_q <= errCount_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign out_data  = s2Data_q;
  assign out_mask  = s2Mask_q;
  assign out_syn   = s2Syn_q;
  assign out_perr  = s2Perr_q;
  assign err_count = errCount_q;

endmodule

// File: tb/tb_syndrome_stage.sv
// Bench for syndrome_stage: a default-width and a 2-bit-counter instance share
// stimulus; a queue model built from the Hamming rules predicts every word.
module tb_syndrome_stage;

  typedef struct packed {
    logic [10:0] data;
    logic [10:0] mask;
    logic [3:0]  syn;
    logic        perr;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [14:0] in_cw = '0;

  logic        bInReady, bOutValid, bOutPerr;
  logic [10:0] bOutData, bOutMask;
  logic [3:0]  bOutSyn;
  logic [15:0] bErrCount;
  logic        sInReady, sOutValid, sOutPerr;
  logic [10:0] sOutData, sOutMask;
  logic [3:0]  sOutSyn;
  logic [1:0]  sErrCount;

  int vectors = 0;
  int miscompares = 0;
  int modelErr = 0;
  int spurious = 0;
  int acceptCount = 0;
  word_t pipeQ[$];
  word_t expQ[$];
  word_t actQ[$];
  word_t monEntry;

  logic [14:0] dirCw   [4] = '{15'h0000, 15'h0004, 15'h0080, 15'h4000};
  logic [10:0] dirData [4] = '{11'h000, 11'h001, 11'h000, 11'h400};
  logic [10:0] dirMask [4] = '{11'h000, 11'h001, 11'h000, 11'h400};
  logic [3:0]  dirSyn  [4] = '{4'd0, 4'd3, 4'd8, 4'd15};
  logic        dirPerr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int          dirErr  [4] = '{0, 1, 2, 3};

  syndrome_stage #(.CNT_W(16)) dutBig (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(bInReady),
    .in_cw(in_cw), .out_valid(bOutValid), .out_ready(out_ready),
    .out_data(bOutData), .out_mask(bOutMask), .out_syn(bOutSyn),
    .out_perr(bOutPerr), .err_count(bErrCount)
  );

  syndrome_stage #(.CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sInReady),
    .in_cw(in_cw), .out_valid(sOutValid), .out_ready(out_ready),
    .out_data(sOutData), .out_mask(sOutMask), .out_syn(sOutSyn),
    .out_perr(sOutPerr), .err_count(sErrCount)
  );

  always #5 clk = ~clk;

  // Reference: syndrome bit k is the parity of positions whose index has bit k set
  function automatic word_t refWord(input logic [14:0] cw);
    word_t w;
    int j;
    logic b;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      b = 1'b0;
      for (int p = 1; p <= 15; p++) if (((p >> k) & 1) == 1) b = b ^ cw[p-1];
      w.syn[k] = b;
    end
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        w.data[j] = cw[p-1];
        if (int'(w.syn) == p) w.mask[j] = 1'b1;
        j++;
      end
    end
    w.perr = (w.syn == 4'd1) || (w.syn == 4'd2) || (w.syn == 4'd4) || (w.syn == 4'd8);
    return w;
  endfunction

  // Transaction monitor: accepted words enter a FIFO, deliveries pair with its head
  always @(posedge clk) begin
    if (reset) begin
      pipeQ.delete();
      expQ.delete();
      actQ.delete();
      modelErr = 0;
    end else begin
      if (bOutValid && out_ready) begin
        if (pipeQ.size() == 0) begin
          spurious++;
        end else begin
          monEntry = pipeQ.pop_front();
          if (monEntry.syn != 4'd0) modelErr++;
          expQ.push_back(monEntry);
          actQ.push_back('{data: bOutData, mask: bOutMask, syn: bOutSyn, perr: bOutPerr});
        end
      end
      if (in_valid && bInReady) begin
        pipeQ.push_back(refWord(in_cw));
        acceptCount++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit timedOut);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    timedOut  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (pipeQ.size() == 0) begin
        timedOut = 1'b0;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_cw = 15'($urandom); out_ready = 1'b1;
    repeat (3) step();
    vectors++; if (bOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b expected 0", bOutValid); end
    vectors++; if (bErrCount !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_err_count got %0d expected 0", bErrCount); end
    vectors++; if (sErrCount !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_err_count_small got %0d expected 0", sErrCount); end
    vectors++; if (bOutData !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_out_data got %h expected 0", bOutData); end
    vectors++; if (bOutMask !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_out_mask got %h expected 0", bOutMask); end
    vectors++; if (bOutSyn !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_out_syn got %h expected 0", bOutSyn); end
    vectors++; if (bOutPerr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_perr got %b expected 0", bOutPerr); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    vectors++; if (bInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b expected 1", bInReady); end
  endtask

  task automatic test_directed();
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1; in_cw = dirCw[n]; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      vectors++; if (bOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL dir%0d_early_valid got %b expected 0", n, bOutValid); end
      step();
      vectors++; if (bOutValid !== 1'b1) begin miscompares++; $display("[TB] FAIL dir%0d_latency_valid got %b expected 1", n, bOutValid); end
      vectors++; if (bOutData !== dirData[n]) begin miscompares++; $display("[TB] FAIL dir%0d_data got %h expected %h", n, bOutData, dirData[n]); end
      vectors++; if (bOutMask !== dirMask[n]) begin miscompares++; $display("[TB] FAIL dir%0d_mask got %h expected %h", n, bOutMask, dirMask[n]); end
      vectors++; if (bOutSyn !== dirSyn[n]) begin miscompares++; $display("[TB] FAIL dir%0d_syn got %h expected %h", n, bOutSyn, dirSyn[n]); end
      vectors++; if (bOutPerr !== dirPerr[n]) begin miscompares++; $display("[TB] FAIL dir%0d_perr got %b expected %b", n, bOutPerr, dirPerr[n]); end
      step();
      vectors++; if (int'(bErrCount) !== dirErr[n]) begin miscompares++; $display("[TB] FAIL dir%0d_err_count got %0d expected %0d", n, bErrCount, dirErr[n]); end
      vectors++; if (bOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL dir%0d_duplicate got %b expected 0", n, bOutValid); end
    end
    expQ.delete();
    actQ.delete();
  endtask

  task automatic test_back_to_back();
    bit timedOut;
    word_t e, a, held;
    int acceptStart, expBig, expSmall;
    acceptStart = acceptCount;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_cw = 15'($urandom);
      step();
    end
    out_ready = 1'b0; in_cw = 15'($urandom);
    #1;
    vectors++; if (bInReady !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_full_in_ready got %b expected 0", bInReady); end
    held = '{data: bOutData, mask: bOutMask, syn: bOutSyn, perr: bOutPerr};
    for (int i = 0; i < 3; i++) begin
      step();
      a = '{data: bOutData, mask: bOutMask, syn: bOutSyn, perr: bOutPerr};
      vectors++; if (bOutValid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_stall_valid got %b expected 1", bOutValid); end
      vectors++; if (a !== held) begin miscompares++; $display("[TB] FAIL b2b_stall_hold got %h expected %h", a, held); end
      vectors++; if (bInReady !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_stall_in_ready got %b expected 0", bInReady); end
    end
    drain(timedOut);
    vectors++; if (timedOut !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain timed_out got %b expected 0", timedOut); end
    vectors++; if (acceptCount - acceptStart !== 6) begin miscompares++; $display("[TB] FAIL b2b_throughput accepted %0d expected 6", acceptCount - acceptStart); end
    vectors++; if (actQ.size() !== 6) begin miscompares++; $display("[TB] FAIL b2b_delivered got %0d expected 6", actQ.size()); end
    while (expQ.size() > 0 && actQ.size() > 0) begin
      e = expQ.pop_front(); a = actQ.pop_front();
      vectors++; if (a !== e) begin miscompares++; $display("[TB] FAIL b2b_word got %h expected %h", a, e); end
    end
    expQ.delete(); actQ.delete();
    expBig = (modelErr > 65535) ? 65535 : modelErr;
    expSmall = (modelErr > 3) ? 3 : modelErr;
    vectors++; if (int'(bErrCount) !== expBig) begin miscompares++; $display("[TB] FAIL b2b_err_count got %0d expected %0d", bErrCount, expBig); end
    vectors++; if (int'(sErrCount) !== expSmall) begin miscompares++; $display("[TB] FAIL b2b_err_count_small got %0d expected %0d", sErrCount, expSmall); end
  endtask

  task automatic test_random();
    bit timedOut;
    word_t e, a;
    int expBig, expSmall, spurStart;
    spurStart = spurious;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0:       in_cw = 15'h0000;
        1:       in_cw = 15'(1 << $urandom_range(0, 14));
        default: in_cw = 15'($urandom);
      endcase
      step();
    end
    drain(timedOut);
    vectors++; if (timedOut !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_drain timed_out got %b expected 0", timedOut); end
    vectors++; if (expQ.size() !== actQ.size()) begin miscompares++; $display("[TB] FAIL rand_count got %0d expected %0d", actQ.size(), expQ.size()); end
    while (expQ.size() > 0 && actQ.size() > 0) begin
      e = expQ.pop_front(); a = actQ.pop_front();
      vectors++; if (a !== e) begin miscompares++; $display("[TB] FAIL rand_word got %h expected %h", a, e); end
    end
    expQ.delete(); actQ.delete();
    vectors++; if (spurious !== spurStart) begin miscompares++; $display("[TB] FAIL rand_spurious got %0d expected %0d", spurious, spurStart); end
    expBig = (modelErr > 65535) ? 65535 : modelErr;
    expSmall = (modelErr > 3) ? 3 : modelErr;
    vectors++; if (int'(bErrCount) !== expBig) begin miscompares++; $display("[TB] FAIL rand_err_count got %0d expected %0d", bErrCount, expBig); end
    vectors++; if (int'(sErrCount) !== expSmall) begin miscompares++; $display("[TB] FAIL rand_err_count_small got %0d expected %0d", sErrCount, expSmall); end
  endtask

  task automatic test_reset_midflight();
    int spurStart;
    spurStart = spurious;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_cw = 15'(1 << $urandom_range(0, 14));
      step();
    end
    vectors++; if (bOutValid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_full_valid got %b expected 1", bOutValid); end
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    vectors++; if (bOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_out_valid got %b expected 0", bOutValid); end
    vectors++; if (bErrCount !== 16'd0) begin miscompares++; $display("[TB] FAIL mid_err_count got %0d expected 0", bErrCount); end
    vectors++; if (sErrCount !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_err_count_small got %0d expected 0", sErrCount); end
    vectors++; if (bInReady !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_in_ready got %b expected 1", bInReady); end
    repeat (5) step();
    vectors++; if (spurious !== spurStart) begin miscompares++; $display("[TB] FAIL mid_stale_word got %0d expected %0d", spurious, spurStart); end
    vectors++; if (bOutValid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_idle_valid got %b expected 0", bOutValid); end
  endtask

  task automatic test_saturation();
    bit timedOut;
    word_t e, a;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_cw = 15'(1 << $urandom_range(0, 14));
      step();
    end
    drain(timedOut);
    vectors++; if (timedOut !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_drain timed_out got %b expected 0", timedOut); end
    while (expQ.size() > 0 && actQ.size() > 0) begin
      e = expQ.pop_front(); a = actQ.pop_front();
      vectors++; if (a !== e) begin miscompares++; $display("[TB] FAIL sat_word got %h expected %h", a, e); end
    end
    expQ.delete(); actQ.delete();
    vectors++; if (sErrCount !== 2'd3) begin miscompares++; $display("[TB] FAIL sat_err_count_small got %0d expected 3", sErrCount); end
    vectors++; if (bErrCount !== 16'd5) begin miscompares++; $display("[TB] FAIL sat_err_count got %0d expected 5", bErrCount); end
    in_valid = 1'b1; in_cw = 15'h0002;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    vectors++; if (sErrCount !== 2'd3) begin miscompares++; $display("[TB] FAIL sat_hold_small got %0d expected 3", sErrCount); end
    vectors++; if (bErrCount !== 16'd6) begin miscompares++; $display("[TB] FAIL sat_hold got %0d expected 6", bErrCount); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not complete got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/syndrome_stage.md
SYNDROME_STAGE -- requirements
Module: syndrome_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning error-counter width.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream codeword valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a codeword this cycle.
REQ-006 SHALL have port in_cw  input  15  received Hamming(15,11) codeword; bit i-1 = position i.
REQ-007 SHALL have port out_valid  output  1  output word valid.
REQ-008 SHALL have port out_ready  input  1  downstream consumes the word.
REQ-009 SHALL have port out_data  output  11  raw (uncorrected) data bits, feeding the 11-bit XOR correction stage.
REQ-010 SHALL have port out_mask  output  11  error mask, XORed downstream with out_data.
REQ-011 SHALL have port out_syn  output  4  syndrome of the word.
REQ-012 SHALL have port out_perr  output  1  syndrome names parity position 1, 2, 4 or 8.
REQ-013 SHALL have port err_count  output  CNT_W  saturating count of delivered words with nonzero syndrome.

Function
REQ-014 SHALL map data bits as follows: data[0..10] = positions 3,5,6,7,9,10,11,12,13,14,15.
REQ-015 SHALL compute syndrome bit k as the XOR of all positions p (1..15) with bit k of p set.
REQ-016 SHALL, for a syndrome equal to a data position, set only the matching out_mask bit; otherwise out_mask SHALL be 0.
REQ-017 SHALL assert out_perr iff syndrome is 1, 2, 4 or 8.
REQ-018 SHALL be a two-stage pipeline: S1 registers in_cw and its syndrome, and S2 registers data, mask, syn and perr.
REQ-019 SHALL give a latency of 2 cycles from acceptance to out_valid when not stalled.
REQ-020 SHALL sustain a throughput of 1 word/cycle while out_ready=1.
REQ-021 SHALL transfer a word iff valid&&ready on that interface in the same cycle.
REQ-022 SHALL advance S2 when !s2_valid || out_ready.
REQ-023 SHALL advance S1 when !s1_valid || S2 advances.
REQ-024 SHALL drive in_ready = !s1_valid || S2 advances; in_ready SHALL be combinational from out_ready, with no registered-ready bubble.
REQ-025 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-026 SHALL never drop or duplicate a word.
REQ-027 SHALL increment err_count by 1 on each output handshake with out_syn!=0.
REQ-028 SHALL saturate err_count at 2^CNT_W-1 with no wrap.
REQ-029 SHALL, on simultaneous acceptance and delivery, perform both in the same cycle with occupancy unchanged.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, clear s1_valid and s2_valid, drive out_valid=0, clear err_count to 0, and zero out_data, out_mask, out_syn and out_perr.
REQ-031 SHALL discard in-flight words on reset mid-operation; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 SHALL ignore in_valid during reset.

Structure
REQ-033 SHALL take DATA_W=11, CW_W=15, SYN_W=4 and the data-position table from shared package hamming_pkg, which the XOR stage also uses.
REQ-034 SHALL place the combinational syndrome-to-mask decode in sub-module syndrome_to_mask (4-bit in, 11-bit mask plus perr out).
REQ-035 SHALL keep the handshake and counter logic in syndrome_stage.

Verification
REQ-036 SHALL cover: in_cw=15'h0000 accepted at cycle 0, out_ready=1 -> cycle 2 out_valid=1, data=0, mask=0, syn=0, err_count=0.
REQ-037 SHALL cover: in_cw=15'h0004 (position 3 flipped) -> syn=3, mask=11'h001, data=11'h001, perr=0, err_count=1.
REQ-038 SHALL cover: in_cw=15'h0080 (position 8 flipped) -> syn=8, mask=0, perr=1; in_cw=15'h4000 (position 15) -> syn=15, mask=11'h400.
REQ-039 SHALL cover: back-to-back stream, then out_ready=0 for 3 cycles -> in_ready=0 once both stages are full, out_* held stable, and all words delivered in order after release.
REQ-040 SHALL cover: reset asserted with both stages full -> next cycle out_valid=0, err_count=0, in_ready=1, and no stale word ever appears.
REQ-041 SHALL cover: CNT_W=2 with 5 erroneous words delivered -> err_count = 3, held.
